pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Sequences the ID/EX/MEM/WB pipeline around the execute stage.
- Keeps a register-destination scoreboard of in-flight instructions and stalls IF/ID on read-after-write hazards (there is no forwarding path).
- Drives the ID/EX `flush` bubble and the IF/ID kill on taken branches and jumps resolved in EX.
- Keeps saturating stall and flush performance counters.

Parameters:
- DEPTH, 3: scoreboard entries, indexed 1=EX, 2=MEM, 3=WB.
- WB_BYPASS, 1: 1 = the register file writes before it reads in the same cycle, so the WB entry is excluded from hazard checks.
- FLUSH_CYCLES, 1: cycles the FLUSH state holds the IF/ID kill after a redirect (1..15).
- CNT_W, 16: performance-counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- valid_D  in  1  instruction present in ID.
- rs_addr_D  in  5  ID source register rs.
- rt_addr_D  in  5  ID source register rt.
- uses_rs_D  in  1  ID instruction reads rs.
- uses_rt_D  in  1  ID instruction reads rt.
- wb_addr_D  in  5  ID destination (RegDst/jal already resolved).
- RegWriteD  in  1  ID instruction writes the register file.
- redirect_E  in  1  taken branch/jump resolved in EX (BranchE&ALUOut[0] | JumpE).
- stall_F  out  1  hold the PC.
- stall_D  out  1  hold the IF/ID register.
- flush_D  out  1  zero the IF/ID register at the next edge.
- flush_E  out  1  bubble into ID/EX at the next edge (the EX-stage `flush` input).
- hazard_busy  out  1  state != RUN.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of redirects.

Behaviour:
- Reset (RSTn=0, asynchronous): state=RUN; all scoreboard entries invalid; flush counter=0; stall_cnt=0; flush_cnt=0.
  - All outputs then evaluate to 0, given valid_D=0 and redirect_E=0.
- Scoreboard entry = {v, addr}.
  - A match on src means: v=1 & addr==src & src!=0.
- hazard = valid_D & state!=FLUSH & ((uses_rs_D & match(rs_addr_D)) | (uses_rt_D & match(rt_addr_D))).
  - Entries searched: 1..DEPTH-WB_BYPASS.
  - Register $0 never hazards.
- Combinational outputs:
  - stall_F = stall_D = hazard & !redirect_E.
  - flush_E = hazard | redirect_E | state==FLUSH.
  - flush_D = redirect_E | state==FLUSH.
- Priority: redirect_E beats hazard. A stalled instruction in ID is wrong-path when EX redirects, so it is killed, not held.
- Scoreboard update, every rising edge:
  - SB[k] <= SB[k-1] for k=2..DEPTH.
  - If flush_E=1: SB[1] <= invalid.
  - Otherwise: SB[1] <= {valid_D & RegWriteD & wb_addr_D!=0, wb_addr_D}.
  - The oldest entry is dropped.
- FSM:
  - RUN: redirect_E → FLUSH with cnt=FLUSH_CYCLES-1. If FLUSH_CYCLES=1, the redirect cycle alone suffices: go to FLUSH only when FLUSH_CYCLES>1, otherwise stay in RUN. hazard → STALL. Else stay in RUN.
  - STALL: redirect_E → as in RUN. !hazard → RUN. Else stay in STALL.
  - FLUSH: redirect_E → restart cnt=FLUSH_CYCLES-1. cnt==1 → RUN. Else cnt--.
- Stall latency:
  - A load/ALU producer directly ahead of a consumer stalls ID for DEPTH-WB_BYPASS cycles (2 with defaults).
  - Producer two ahead: 1 cycle. Producer three ahead: 0 cycles.
- Counters:
  - stall_cnt increments on each cycle with stall_D=1.
  - flush_cnt increments on each cycle with redirect_E=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-stall or mid-flush: returns immediately to RUN with an empty scoreboard.
- Simultaneous hazard and redirect: stall=0, flush_D=1, flush_E=1, counted only in flush_cnt.

Test Plan:
1. Reset, then RSTn=1 with idle inputs → all outputs 0 for 5 cycles; stall_cnt=0.
2. Issue add $3 (RegWrite, wb=3), then next cycle issue or $5,$3,$4 (uses_rs, rs=3) → stall_D=1 for exactly 2 cycles, flush_E=1 in those cycles, released on cycle 3; stall_cnt=2.
3. Producer wb=3, one independent instruction, then a consumer of $3 → 1 stall cycle. Consumer of $0 after a producer with wb=0 → no stall.
4. redirect_E=1 in the same cycle as a pending hazard → stall_D=0, flush_D=1, flush_E=1; SB[1] invalid next cycle; flush_cnt=1.
5. FLUSH_CYCLES=3, redirect_E pulse → flush_D high for 3 consecutive cycles, hazard_busy high for 2, then RUN.
6. CNT_W=4, hold a hazard for 20 cycles → stall_cnt saturates at 15; assert RSTn=0 mid-stall → outputs 0 and counters 0 asynchronously, before the next edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl - RAW-stall scoreboard, redirect flush sequencing, perf counters
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int DEPTH        = 3,
  parameter int WB_BYPASS    = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             valid_D,
  input  logic [4:0]       rs_addr_D,
  input  logic [4:0]       rt_addr_D,
  input  logic             uses_rs_D,
  input  logic             uses_rt_D,
  input  logic [4:0]       wb_addr_D,
  input  logic             RegWriteD,
  input  logic             redirect_E,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             flush_E,
  output logic             hazard_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int             SEARCH     = DEPTH - WB_BYPASS;
  localparam logic [3:0]     FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [DEPTH:1]   sb_v_q, sb_v_d;
  logic [4:0]       sb_addr_q [1:DEPTH];
  logic [4:0]       sb_addr_d [1:DEPTH];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             rs_hit, rt_hit, hazard;
  logic             sb_wb_unused;

  // The oldest (WB) entry only ages out; it is never searched when the
  // register file writes before it reads.
  assign sb_wb_unused = ^{sb_v_q[DEPTH], sb_addr_q[DEPTH]};

  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int k = 1; k <= SEARCH; k++) begin
      if (sb_v_q[k] && (sb_addr_q[k] == rs_addr_D) && (rs_addr_D != 5'd0)) rs_hit = 1'b1;
      if (sb_v_q[k] && (sb_addr_q[k] == rt_addr_D) && (rt_addr_D != 5'd0)) rt_hit = 1'b1;
    end
  end

  assign hazard      = valid_D && (state_q != FLUSH) &&
                       ((uses_rs_D && rs_hit) || (uses_rt_D && rt_hit));
  // A redirect makes the ID instruction wrong-path, so it is killed, not held.
  assign stall_F     = hazard && !redirect_E;
  assign stall_D     = stall_F;
  assign flush_E     = hazard || redirect_E || (state_q == FLUSH);
  assign flush_D     = redirect_E || (state_q == FLUSH);
  assign hazard_busy = (state_q != RUN);
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

  always_comb begin
    sb_v_d[1]    = !flush_E && valid_D && RegWriteD && (wb_addr_D != 5'd0);
    sb_addr_d[1] = wb_addr_D;
    for (int k = 2; k <= DEPTH; k++) begin
      sb_v_d[k]    = sb_v_q[k-1];
      sb_addr_d[k] = sb_addr_q[k-1];
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      RUN, STALL: begin
        if (redirect_E) begin
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_INIT;
          end else begin
            state_d = RUN;
          end
        end else if (hazard) begin
          state_d = STALL;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (redirect_E) begin
          fcnt_d = FLUSH_INIT;
        end else if (fcnt_q == 4'd1) begin
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_D && (stall_cnt_q != '1))    stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (redirect_E && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= RUN;
      fcnt_q      <= 4'd0;
      sb_v_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      for (int k = 1; k <= DEPTH; k++) sb_addr_q[k] <= 5'd0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      sb_v_q      <= sb_v_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      for (int k = 1; k <= DEPTH; k++) sb_addr_q[k] <= sb_addr_d[k];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl - directed bench for the default and a FLUSH_CYCLES=3/CNT_W=4 build
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  logic       CLK;
  logic       RSTn;
  logic       valid_D, uses_rs_D, uses_rt_D, RegWriteD, redirect_E;
  logic [4:0] rs_addr_D, rt_addr_D, wb_addr_D;

  logic        d_sF, d_sD, d_fD, d_fE, d_busy;
  logic [15:0] d_scnt, d_fcnt;
  logic        a_sF, a_sD, a_fD, a_fE, a_busy;
  logic [3:0]  a_scnt, a_fcnt;

  logic [4:0] d_out, a_out;
  assign d_out = {d_sF, d_sD, d_fD, d_fE, d_busy};
  assign a_out = {a_sF, a_sD, a_fD, a_fE, a_busy};

  pipeline_hazard_ctrl u_dflt (
    .CLK(CLK), .RSTn(RSTn), .valid_D(valid_D), .rs_addr_D(rs_addr_D), .rt_addr_D(rt_addr_D),
    .uses_rs_D(uses_rs_D), .uses_rt_D(uses_rt_D), .wb_addr_D(wb_addr_D), .RegWriteD(RegWriteD),
    .redirect_E(redirect_E), .stall_F(d_sF), .stall_D(d_sD), .flush_D(d_fD), .flush_E(d_fE),
    .hazard_busy(d_busy), .stall_cnt(d_scnt), .flush_cnt(d_fcnt)
  );

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) u_alt (
    .CLK(CLK), .RSTn(RSTn), .valid_D(valid_D), .rs_addr_D(rs_addr_D), .rt_addr_D(rt_addr_D),
    .uses_rs_D(uses_rs_D), .uses_rt_D(uses_rt_D), .wb_addr_D(wb_addr_D), .RegWriteD(RegWriteD),
    .redirect_E(redirect_E), .stall_F(a_sF), .stall_D(a_sD), .flush_D(a_fD), .flush_E(a_fE),
    .hazard_busy(a_busy), .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // outs = {stall_F, stall_D, flush_D, flush_E, hazard_busy}; sel 0=default, 1=alt, 2=both
  typedef struct {
    string      tag;
    int         sel;
    logic [4:0] outs;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] wb, input logic rw, input logic rd);
    valid_D = v;  rs_addr_D = rs; uses_rs_D = urs; rt_addr_D = rt;
    uses_rt_D = urt; wb_addr_D = wb; RegWriteD = rw; redirect_E = rd;
  endtask

  task automatic compare_head();
    exp_t x;
    x = q.pop_front();
    if (x.sel != 1) check({x.tag, "/dflt"}, {27'd0, d_out}, {27'd0, x.outs});
    if (x.sel != 0) check({x.tag, "/alt"},  {27'd0, a_out}, {27'd0, x.outs});
  endtask

  // One clock cycle: drive ID inputs, queue the expected outputs, compare on the falling edge.
  task automatic step(input string tag, input int sel, input logic v, input logic [4:0] rs,
                      input logic urs, input logic [4:0] rt, input logic urt, input logic [4:0] wb,
                      input logic rw, input logic rd, input logic [4:0] e);
    drive(v, rs, urs, rt, urt, wb, rw, rd);
    q.push_back('{tag, sel, e});
    @(negedge CLK);
    compare_head();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input string tag, input int sel, input logic [4:0] e);
    step(tag, sel, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/dflt_out"},  {27'd0, d_out}, 32'd0);
    check({tag, "/alt_out"},   {27'd0, a_out}, 32'd0);
    check({tag, "/dflt_scnt"}, {16'd0, d_scnt}, 32'd0);
    check({tag, "/dflt_fcnt"}, {16'd0, d_fcnt}, 32'd0);
    check({tag, "/alt_scnt"},  {28'd0, a_scnt}, 32'd0);
    check({tag, "/alt_fcnt"},  {28'd0, a_fcnt}, 32'd0);
  endtask

  // Reset is asserted between edges so its effect is seen before any clock.
  task automatic do_reset(input string tag);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #2 RSTn = 1'b0;
    #1 check_all_zero(tag);
    @(posedge CLK);
    #1 RSTn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTn = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    do_reset("reset0");

    // Idle after reset
    for (int i = 0; i < 5; i++) idle("t1_idle", 2, 5'b00000);
    check("t1_scnt", {16'd0, d_scnt}, 32'd0);

    // Back-to-back dependency: two stall cycles
    step("t2_prod",  2, 1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 5'b00000);
    step("t2_st1",   2, 1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 5'b11010);
    step("t2_st2",   2, 1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 5'b11011);
    step("t2_rel",   2, 1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 5'b00001);
    for (int i = 0; i < 3; i++) idle("t2_idle", 2, 5'b00000);
    check("t2_scnt_dflt", {16'd0, d_scnt}, 32'd2);
    check("t2_scnt_alt",  {28'd0, a_scnt}, 32'd2);

    // Producer two ahead: one stall cycle
    step("t3_prod",  2, 1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 5'b00000);
    step("t3_indep", 2, 1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 0, 5'b00000);
    step("t3_cons",  2, 1, 5'd3, 1, 5'd0, 0, 5'd9, 1, 0, 5'b11010);
    step("t3_rel",   2, 1, 5'd3, 1, 5'd0, 0, 5'd9, 1, 0, 5'b00001);
    for (int i = 0; i < 3; i++) idle("t3_idle", 2, 5'b00000);
    check("t3_scnt", {16'd0, d_scnt}, 32'd3);

    // $0 never hazards
    step("t3_p0",    2, 1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 5'b00000);
    step("t3_c0",    2, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 5'b00000);
    for (int i = 0; i < 3; i++) idle("t3_idle0", 2, 5'b00000);

    // uses_rs gating, then a producer three ahead sits in WB and is bypassed
    step("t3_p6",    2, 1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 0, 5'b00000);
    step("t3_gate",  2, 1, 5'd6, 0, 5'd0, 0, 5'd0, 0, 0, 5'b00000);
    step("t3_ind2",  2, 1, 5'd2, 1, 5'd0, 0, 5'd8, 1, 0, 5'b00000);
    step("t3_wb",    2, 1, 5'd0, 0, 5'd6, 1, 5'd0, 0, 0, 5'b00000);
    for (int i = 0; i < 3; i++) idle("t3_idle6", 2, 5'b00000);
    check("t3_scnt_end", {16'd0, d_scnt}, 32'd3);

    // Redirect beats a pending hazard; the killed instruction never enters the scoreboard
    step("t4_prod",  0, 1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 5'b00000);
    step("t4_redir", 0, 1, 5'd3, 1, 5'd0, 0, 5'd5, 1, 1, 5'b00110);
    step("t4_sb1",   0, 1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 5'b00000);
    check("t4_fcnt", {16'd0, d_fcnt}, 32'd1);
    check("t4_scnt", {16'd0, d_scnt}, 32'd3);
    for (int i = 0; i < 3; i++) idle("t4_idle", 0, 5'b00000);

    // FLUSH_CYCLES=3: three flush_D cycles, two busy, hazards masked while flushing
    do_reset("reset5");
    step("t5_prod",  2, 1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 5'b00000);
    step("t5_redir", 2, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'b00110);
    step("t5_fl1",   1, 1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 5'b00111);
    idle("t5_fl2", 1, 5'b00111);
    idle("t5_run", 1, 5'b00000);
    idle("t5_idle", 1, 5'b00000);
    check("t5_fcnt_alt", {28'd0, a_fcnt}, 32'd1);
    check("t5_scnt_alt", {28'd0, a_scnt}, 32'd0);
    check("t5_scnt_dflt", {16'd0, d_scnt}, 32'd1);

    // Dependent chain: 2 stalls per instruction, 16 stalls total saturate the 4-bit counter
    step("t6_seed",  2, 1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 0, 5'b00000);
    for (int i = 0; i < 8; i++) begin
      step("t6_st1", 2, 1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 0, 5'b11010);
      step("t6_st2", 2, 1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 0, 5'b11011);
      step("t6_acc", 2, 1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 0, 5'b00001);
    end
    check("t6_scnt_alt_sat", {28'd0, a_scnt}, 32'd15);
    check("t6_scnt_dflt",    {16'd0, d_scnt}, 32'd17);

    // Reset while in STALL takes effect before the next edge
    step("t6_st1b", 2, 1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 0, 5'b11010);
    q.push_back('{"t6_st2b", 2, 5'b11011});
    @(negedge CLK);
    compare_head();
    #2 RSTn = 1'b0;
    #1 check_all_zero("t6_midrst");
    @(posedge CLK);
    #1 RSTn = 1'b1;
    idle("t6_after", 2, 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
